// File: rtl/demux_pkg.sv
// Shared constants, scan-state encoding and debug view for the 1-to-16 registered demux.
package demux_pkg;

  localparam int N_CH  = 16;
  localparam int SEL_W = 4;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } scan_state_e;

  typedef struct packed {
    scan_state_e      state;
    logic [SEL_W-1:0] ptr;
  } scan_dbg_t;

endpackage

// File: rtl/decoder_4to16.sv
// One-hot decoder with enable; feeds both the out write enable and the strb pulse.
module decoder_4to16
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0] idx,
  input  logic             en,
  output logic [N_CH-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N_CH; i++) begin
      onehot[i] = en && (idx == SEL_W'(i));
    end
  end

endmodule

// File: rtl/demux_1to16_reg.sv
// Registered 1-to-16 bit demux with optional auto-scan frame capture (DEMUX16_AUTOSCAN_EN).
// Handshake: a beat moves when in_valid && in_ready; a frame moves when frame_valid && frame_ready.
module demux_1to16_reg
  import demux_pkg::*;
#(
  parameter logic [N_CH-1:0] RESET_VAL = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic [SEL_W-1:0] sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             scan_mode,
  output logic [N_CH-1:0]  out,
  output logic [N_CH-1:0]  strb,
  output logic [N_CH-1:0]  frame_data,
  output logic             frame_valid,
  input  logic             frame_ready
);

  logic [SEL_W-1:0] dest;
  logic             accept;
  logic [N_CH-1:0]  wr_oh;
  logic [N_CH-1:0]  out_q, out_d;
  logic [N_CH-1:0]  strb_q, strb_d;

  assign accept = in_valid && in_ready;
  assign out    = out_q;
  assign strb   = strb_q;

  decoder_4to16 u_dec (
    .idx    (dest),
    .en     (accept),
    .onehot (wr_oh)
  );

  always_comb begin
    out_d  = (out_q & ~wr_oh) | ({N_CH{din}} & wr_oh);
    strb_d = wr_oh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= RESET_VAL;
      strb_q <= '0;
    end else begin
      out_q  <= out_d;
      strb_q <= strb_d;
    end
  end

`ifdef DEMUX16_AUTOSCAN_EN
  scan_state_e      state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [N_CH-1:0]  frame_data_q, frame_data_d;
  logic             frame_valid_q, frame_valid_d;
  logic             last_beat;
  logic             xfer;
  scan_dbg_t        dbg;

  assign dbg         = '{state: state_q, ptr: ptr_q};
  assign in_ready    = scan_mode ? (!frame_valid_q || frame_ready) : 1'b1;
  assign dest        = scan_mode ? ptr_q : sel;
  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;

  // Every channel is rewritten during a frame, so the frame is simply out_d on the ptr=15 beat.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = frame_valid_q;
    last_beat     = accept && scan_mode && (ptr_q == {SEL_W{1'b1}});
    xfer          = frame_valid_q && frame_ready;
    if (!scan_mode) begin
      ptr_d = '0;
    end else if (accept) begin
      ptr_d = ptr_q + 1'b1;
    end
    case (state_q)
      FILL: begin
        if (last_beat) begin
          state_d       = FULL;
          frame_data_d  = out_d;
          frame_valid_d = 1'b1;
        end
      end
      FULL: begin
        if (last_beat) begin
          frame_data_d = out_d;
        end else if (xfer) begin
          state_d       = FILL;
          frame_valid_d = 1'b0;
        end
      end
      default: begin
        state_d       = FILL;
        frame_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FILL;
      ptr_q         <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
    end
  end
`else
  logic unused_scan_inputs;

  assign unused_scan_inputs = ^{scan_mode, frame_ready};
  assign in_ready           = 1'b1;
  assign dest               = sel;
  assign frame_data         = '0;
  assign frame_valid        = 1'b0;
`endif

endmodule
